// File: rtl/bnn_pkg.sv
// Shared types and helpers for the BNN convolution datapath.
package bnn_pkg;

  // Frame-tracking states of the window generator.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  // LSB position of tap (r,c) inside a flattened K*K window of data_w-bit pixels.
  function automatic int tap_lsb(input int r, input int c, input int k, input int data_w);
    return (r * k + c) * data_w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular line memory: combinational read and synchronous write at one shared
// address, so a read in the write cycle returns the value from before the write.
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Old contents are visible during the cycle that overwrites them.
  assign rdata = mem[addr];

  // Store the incoming column value for the next row to read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding K x K window generator over a raster pixel stream with runtime
// image size, valid gating, frame tracking and configuration checking.
//
// Handshake: in_valid marks a pixel on din in that cycle; there is no ready,
// the block accepts every beat. Outputs follow each accepted beat by exactly
// one cycle; win_valid/frame_done are single-cycle qualifiers, win holds.
module conv_window_gen
  import bnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int K      = 5,
  parameter int MAX_W  = 28,
  parameter int MAX_H  = 28,
  parameter int WW     = $clog2(MAX_W + 1),
  parameter int HW     = $clog2(MAX_H + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din,
  input  logic [WW-1:0]            cfg_w,
  input  logic [HW-1:0]            cfg_h,
  output logic                     win_valid,
  output logic [K*K*DATA_W-1:0]    win,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     cfg_err
);

  localparam int AW = $clog2(MAX_W);

  state_e                   state_q, state_d;
  logic [HW-1:0]            row_q;
  logic [WW-1:0]            col_q;
  logic [WW-1:0]            lat_w_m1;
  logic [HW-1:0]            lat_h_m1;
  logic                     win_valid_q, frame_done_q, busy_q, cfg_err_q;
  logic signed [DATA_W-1:0] win_q [K][K];
  logic signed [DATA_W-1:0] line_rd [K-1];

  logic          beat, cfg_ok, last, emit;
  logic [WW-1:0] in_w_m1, w_m1, cur_col, next_col;
  logic [HW-1:0] in_h_m1, h_m1, cur_row, next_row;

  // Position of the current beat, last-pixel detection and next-state logic.
  // Out-of-range sizes are clamped so an error frame still terminates.
  always_comb begin
    beat    = in_valid & ~rst;
    cfg_ok  = (cfg_w >= WW'(K)) && (cfg_w <= WW'(MAX_W)) &&
              (cfg_h >= HW'(K)) && (cfg_h <= HW'(MAX_H));
    in_w_m1 = (cfg_w > WW'(MAX_W)) ? WW'(MAX_W - 1) :
              (cfg_w == '0)        ? '0 : cfg_w - WW'(1);
    in_h_m1 = (cfg_h > HW'(MAX_H)) ? HW'(MAX_H - 1) :
              (cfg_h == '0)        ? '0 : cfg_h - HW'(1);
    if (state_q == IDLE) begin
      cur_row = '0;
      cur_col = '0;
      w_m1    = in_w_m1;
      h_m1    = in_h_m1;
    end else begin
      cur_row = row_q;
      cur_col = col_q;
      w_m1    = lat_w_m1;
      h_m1    = lat_h_m1;
    end
    last = (cur_col == w_m1) && (cur_row == h_m1);
    emit = (state_q == RUN) && (cur_row >= HW'(K - 1)) && (cur_col >= WW'(K - 1));
    next_col = cur_col + WW'(1);
    next_row = cur_row;
    if (last) begin
      next_col = '0;
      next_row = '0;
    end else if (cur_col == w_m1) begin
      next_col = '0;
      next_row = cur_row + HW'(1);
    end
    state_d = state_q;
    if (beat) begin
      if (last)                   state_d = IDLE;
      else if (state_q == IDLE)   state_d = cfg_ok ? RUN : ERR;
    end
  end

  // Control state: FSM, counters, latched configuration and output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      lat_w_m1     <= '0;
      lat_h_m1     <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_valid_q  <= beat & emit;
      frame_done_q <= beat & last;
      if (beat) begin
        row_q  <= next_row;
        col_q  <= next_col;
        busy_q <= ~last;
        if (state_q == IDLE) begin
          lat_w_m1  <= in_w_m1;
          lat_h_m1  <= in_h_m1;
          cfg_err_q <= ~cfg_ok;
        end
      end
    end
  end

  // Window shift: older columns move toward higher c, column 0 takes the new
  // pixel stacked on the same column of the previous K-1 rows.
  always_ff @(posedge clk) begin
    if (beat) begin
      for (int r = 0; r < K; r++) begin
        for (int c = K - 1; c > 0; c--) win_q[r][c] <= win_q[r][c-1];
      end
      win_q[0][0] <= din;
      for (int r = 1; r < K; r++) win_q[r][0] <= line_rd[r-1];
    end
  end

  // K-1 line memories chained so line i holds the row i+1 above the current one.
  for (genvar i = 0; i < K - 1; i++) begin : g_line
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    if (i == 0) begin : g_first
      assign wdata = din;
    end else begin : g_rest
      assign wdata = line_rd[i-1];
    end
    assign line_rd[i] = rdata;
    line_buffer #(.DEPTH(MAX_W), .WIDTH(DATA_W), .AW(AW)) u_line (
      .clk   (clk),
      .we    (beat),
      .addr  (cur_col[AW-1:0]),
      .wdata (wdata),
      .rdata (rdata)
    );
  end

  // Flatten the register window into the tap-ordered output bus.
  always_comb begin
    win = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) win[tap_lsb(r, c, K, DATA_W) +: DATA_W] = win_q[r][c];
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: frame table, back-to-back frames,
// mid-frame reset and an out-of-range configuration.
module tb_conv_window_gen;

  localparam int DATA_W = 32;
  localparam int K      = 5;
  localparam int MAX_W  = 28;
  localparam int MAX_H  = 28;
  localparam int WW     = $clog2(MAX_W + 1);
  localparam int HW     = $clog2(MAX_H + 1);
  localparam int WINB   = K * K * DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] din = '0;
  logic [WW-1:0]            cfg_w = '0;
  logic [HW-1:0]            cfg_h = '0;
  logic                     win_valid, frame_done, busy, cfg_err;
  logic [WINB-1:0]          win;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_W(DATA_W), .K(K), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .din        (din),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .win_valid  (win_valid),
    .win        (win),
    .frame_done (frame_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0]     exp_q[$];        // {width[31:16], pixel index[15:0]} of each expected window
  logic [WINB-1:0] first_q[$];      // first window of each frame
  logic            fd_valid_q[$];   // win_valid seen with each frame_done
  int              fd_tap_q[$];     // tap(0,0) seen with each frame_done
  int              win_cnt = 0;
  int              fd_cnt  = 0;
  int              frame_wins = 0;
  logic            beat_seen = 1'b0;
  logic [WINB-1:0] prev_win;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tap(input logic [WINB-1:0] w, input int r, input int c);
    return int'($signed(w[(r * K + c) * DATA_W +: DATA_W]));
  endfunction

  // Whether the previous rising edge accepted a beat.
  always @(posedge clk) beat_seen <= in_valid && !rst;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!beat_seen) begin
      check("win_hold", {31'b0, win === prev_win}, 32'd1);
      check("gap_win_valid", {31'b0, win_valid}, 32'd0);
      check("gap_frame_done", {31'b0, frame_done}, 32'd0);
    end
    if (win_valid === 1'b1) begin
      win_cnt++;
      if (frame_wins == 0) first_q.push_back(win);
      frame_wins++;
      if (exp_q.size() == 0) begin
        check("unexpected_win", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        int w, row, col, r0, c0;
        bit bad;
        e = exp_q.pop_front();
        w = int'(e[31:16]);
        row = int'(e[15:0]) / w;
        col = int'(e[15:0]) % w;
        r0 = 0; c0 = 0; bad = 1'b0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            if (!bad && tap(win, r, c) != (row - r) * w + (col - c)) begin
              bad = 1'b1; r0 = r; c0 = c;
            end
        check("win_tap", tap(win, r0, c0), (row - r0) * w + (col - c0));
      end
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_valid_q.push_back(win_valid);
      fd_tap_q.push_back(tap(win, 0, 0));
      frame_wins = 0;
    end
    if (rst === 1'b1) frame_wins = 0;
    prev_win = win;
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame(input int w, input int h, input int gap, input bit err, input int limit);
    int n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n >= limit) return;
        cfg_w = WW'(w);
        cfg_h = HW'(h);
        in_valid = 1'b1;
        din = DATA_W'(r * w + c);
        if (!err && r >= K - 1 && c >= K - 1) exp_q.push_back(32'((w << 16) | (r * w + c)));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_w = WW'($urandom_range(0, 31));   // must be ignored mid-frame
        cfg_h = HW'($urandom_range(0, 31));
        if (n == 0) begin
          check("busy_rise", {31'b0, busy}, 32'd1);
          check("cfg_err_latch", {31'b0, cfg_err}, {31'b0, err});
        end
        n++;
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic check_first(input int exp00, input int exp21);
    logic [WINB-1:0] fw;
    if (first_q.size() == 0) begin
      check("first_win_seen", 32'd0, 32'd1);
    end else begin
      fw = first_q.pop_front();
      check("first_tap00", tap(fw, 0, 0), exp00);
      check("first_tap44", tap(fw, 4, 4), 0);
      check("first_tap21", tap(fw, 2, 1), exp21);
    end
  endtask

  task automatic check_done(input bit exp_v, input int exp_last);
    logic v;
    int t;
    if (fd_valid_q.size() == 0) begin
      check("done_seen", 32'd0, 32'd1);
    end else begin
      v = fd_valid_q.pop_front();
      t = fd_tap_q.pop_front();
      check("done_with_win", {31'b0, v}, {31'b0, exp_v});
      if (exp_v) check("last_tap00", t, exp_last);
    end
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    int w; int h; int gap; bit err;
    int exp_wins; int exp_first; int exp_t21; int exp_last;
  } frame_t;

  frame_t tbl[4];

  initial begin
    int wb, fb;
    tbl[0] = '{w: 28, h: 28, gap: 0, err: 1'b0, exp_wins: 576, exp_first: 116, exp_t21: 59, exp_last: 783};
    tbl[1] = '{w: 12, h: 12, gap: 3, err: 1'b0, exp_wins: 64,  exp_first: 52,  exp_t21: 27, exp_last: 143};
    tbl[2] = '{w: 3,  h: 28, gap: 0, err: 1'b1, exp_wins: 0,   exp_first: 0,   exp_t21: 0,  exp_last: 0};
    tbl[3] = '{w: 12, h: 12, gap: 1, err: 1'b0, exp_wins: 64,  exp_first: 52,  exp_t21: 27, exp_last: 143};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_win_valid", {31'b0, win_valid}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames, each followed by idle cycles.
    for (int i = 0; i < 4; i++) begin
      wb = win_cnt;
      fb = fd_cnt;
      run_frame(tbl[i].w, tbl[i].h, tbl[i].gap, tbl[i].err, 1 << 20);
      repeat (3) @(posedge clk);
      #1;
      check("win_count", win_cnt - wb, tbl[i].exp_wins);
      check("done_count", fd_cnt - fb, 1);
      check("busy_end", {31'b0, busy}, 32'd0);
      check("cfg_err_end", {31'b0, cfg_err}, {31'b0, tbl[i].err});
      check("sb_empty", exp_q.size(), 0);
      if (tbl[i].exp_wins > 0) check_first(tbl[i].exp_first, tbl[i].exp_t21);
      check_done(tbl[i].exp_wins > 0, tbl[i].exp_last);
    end

    // Back-to-back 28x28 then 12x12 with no idle cycle between.
    wb = win_cnt;
    fb = fd_cnt;
    run_frame(28, 28, 0, 1'b0, 1 << 20);
    run_frame(12, 12, 0, 1'b0, 1 << 20);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_win_count", win_cnt - wb, 640);
    check("b2b_done_count", fd_cnt - fb, 2);
    check("b2b_sb_empty", exp_q.size(), 0);
    check_first(116, 59);
    check_first(52, 27);
    check_done(1'b1, 783);
    check_done(1'b1, 143);

    // Reset on beat (10,15) of a 28x28 frame, then a fresh frame.
    wb = win_cnt;
    fb = fd_cnt;
    run_frame(28, 28, 0, 1'b0, 10 * 28 + 15);
    cfg_w = WW'(28);
    cfg_h = HW'(28);
    in_valid = 1'b1;
    din = DATA_W'(10 * 28 + 15);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_win_valid", {31'b0, win_valid}, 32'd0);
    check("midrst_frame_done", {31'b0, frame_done}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_cfg_err", {31'b0, cfg_err}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    check("partial_wins", win_cnt - wb, 6 * 24 + 11);
    check("partial_done", fd_cnt - fb, 0);
    check("partial_sb_empty", exp_q.size(), 0);
    check_first(116, 59);
    @(posedge clk); #1;
    wb = win_cnt;
    fb = fd_cnt;
    run_frame(28, 28, 0, 1'b0, 1 << 20);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_wins", win_cnt - wb, 576);
    check("post_rst_done", fd_cnt - fb, 1);
    check("post_rst_sb_empty", exp_q.size(), 0);
    check_first(116, 59);
    check_done(1'b1, 783);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Parametrised sliding-window generator for the BNN convolution datapath. It accepts a raster-order pixel stream and presents a full K×K window, all K² taps, for every position where the window lies entirely inside the image. Image width and height are runtime-configurable up to the build-time maximums. It replaces the fixed two-mode 5-tap column buffer and adds per-tap windows, valid gating, frame tracking and configuration checking.

## Interface
Parameters:
- DATA_W, 32: pixel width, signed.
- K, 5: kernel edge, ≥2.
- MAX_W, 28: maximum image width, ≥K.
- MAX_H, 28: maximum image height, ≥K.
- WW = $clog2(MAX_W+1), HW = $clog2(MAX_H+1): derived widths.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  din carries a pixel this cycle. Gaps are allowed; there is no backpressure.
- din  in  DATA_W  signed pixel, raster order (row-major).
- cfg_w  in  WW  image width, sampled on the first beat of each frame.
- cfg_h  in  HW  image height, sampled on the first beat of each frame.
- win_valid  out  1  win holds a complete in-image window.
- win  out  K*K*DATA_W  tap (r,c) at bits [(r*K+c)*DATA_W +: DATA_W] is pixel (row−r, col−c), so tap (0,0) is the newest pixel.
- frame_done  out  1  one-cycle pulse on the output cycle of the frame's last pixel.
- busy  out  1  a frame is in progress.
- cfg_err  out  1  the latched configuration is out of range; sticky until the next frame start or reset.

## Operation
- FSM states:
  - IDLE: the first in_valid beat latches cfg_w and cfg_h. That beat is processed as pixel (0,0). Next state is RUN if K≤cfg_w≤MAX_W and K≤cfg_h≤MAX_H, otherwise ERR.
  - RUN: on each beat, col increments; at cfg_w−1 col wraps to 0 and row increments. On the beat at (cfg_h−1, cfg_w−1), return to IDLE.
  - ERR: beats are consumed and counted with the latched values, saturating at MAX_W/MAX_H. No window is emitted. Return to IDLE on the same last-pixel condition.
- Storage:
  - K−1 circular line memories, depth MAX_W, addressed by col.
  - One K×K register window.
- Per accepted beat:
  - Read line[i][col] for i = 0..K−2.
  - Shift the window one column toward higher c.
  - Load column c=0 with {din, line[0][col], …, line[K−2][col]} for r = 0..K−1.
  - Write line[0][col] ← din and line[i][col] ← line[i−1][col].
  - Read-before-write at the same address is required.
- win_valid = 1 for the beat's output cycle iff state is RUN, row ≥ K−1 and col ≥ K−1. This means no window straddles a row edge.
- Valid windows per frame: (cfg_w−K+1)·(cfg_h−K+1).
- Data is passed unmodified; the block performs no arithmetic.
- A cycle without in_valid leaves all state and the win register unchanged. win_valid and frame_done drop to 0 on such a cycle.

## Timing
- Latency: 1 cycle. A beat accepted in cycle t drives win, win_valid and frame_done in cycle t+1.
- Back-to-back frames: the first beat of frame N+1 may arrive in the cycle immediately after the last beat of frame N. Configuration is re-latched on that beat.
- Reset values: win_valid=0, frame_done=0, busy=0, cfg_err=0, row=col=0, state=IDLE. win and line memories are not reset, because valid gating guarantees they are refilled before use.
- Reset mid-frame: the next in_valid is treated as pixel (0,0) of a new frame. No stale window is ever flagged valid.
- Configuration changes during a frame are ignored.
- busy rises in the output cycle of the first beat. It falls in the frame_done cycle.

## Structure
- Shared package bnn_pkg holds:
  - the FSM state enum (IDLE/RUN/ERR);
  - the tap-index helper function tap_lsb(r,c,K,DATA_W).
- One sub-module, line_buffer: a parametrised depth/width circular memory with combinational read and synchronous write at the same address. It is instantiated K−1 times.
- The counter, FSM and window registers live in the top module.

## Test plan
- K=5, 28×28 frame, din = row·28+col, continuous: 576 win_valid pulses. The first pulse is at beat (4,4) with tap(0,0)=116, tap(4,4)=0 and tap(2,1)=59. frame_done is asserted with the last window, where tap(0,0)=783.
- 12×12 frame, din = row·12+col, random in_valid gaps of 0–3 cycles: exactly 64 windows, contents identical to the gap-free run, win held stable across gaps.
- Back-to-back 28×28 then 12×12 frames with no idle cycle: the second frame's first window appears at its beat (4,4) with tap(4,4)=0 of the new frame. There is no mixing with the previous frame.
- rst asserted at frame 1, beat (10,15), then a fresh 28×28 frame: outputs are reset next cycle, and 576 correct windows follow.
- cfg_w=3 (<K) with 3×28 beats: cfg_err=1, zero win_valid, frame_done pulses once, and the following valid frame runs clean with cfg_err=0.
